inplace_fft_r2_dif: RTL and testbench

64-point radix-2 decimation-in-frequency FFT on 16-bit signed complex samples, computed in place in one 64-word working memory with a single butterfly unit. Samples stream in one per accepted cycle. Stage 1 overlaps the second half of loading, and stages 2–5 run back to back. Stage 6 streams two results per cycle on dual output lanes in bit-reversed order. It sits between a sample source and a downstream spectrum consumer.

---
 rtl/inplace_fft_r2_dif_pkg.sv | 41 ++++
 rtl/inplace_fft_r2_dif_butterfly.sv | 71 +++++++
 rtl/inplace_fft_r2_dif.sv | 167 ++++++++++++++++
 tb/tb_inplace_fft_r2_dif.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inplace_fft_r2_dif_pkg.sv
// Shared constants, state encoding and twiddle table for the 64-point
// in-place radix-2 DIF FFT.
package inplace_fft_r2_dif_pkg;

  localparam int N         = 64;
  localparam int LOG2N     = 6;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // W^k = cos(2*pi*k/64) - j*sin(2*pi*k/64) in Q1.14, k = 0..31
  localparam logic signed [COEF_W-1:0] TW_RE [N/2] = '{
     16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,
     16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
     16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,
     16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606,
     16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,
    -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
    -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449,
    -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305
  };

  localparam logic signed [COEF_W-1:0] TW_IM [N/2] = '{
     16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,
    -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
    -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449,
    -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305,
    -16'sd16384, -16'sd16305, -16'sd16069, -16'sd15679,
    -16'sd15137, -16'sd14449, -16'sd13623, -16'sd12665,
    -16'sd11585, -16'sd10394, -16'sd9102,  -16'sd7723,
    -16'sd6270,  -16'sd4756,  -16'sd3196,  -16'sd1606
  };

endpackage

// File: rtl/inplace_fft_r2_dif_butterfly.sv
// Combinational radix-2 DIF butterfly:
//   top = (a + b) [>>>1],  bot = ((a - b) [>>>1]) * W
// Sum/difference are formed at DATA_W+1 bits; the twiddle product uses
// full-width intermediates, >>> COEF_FRAC, and wraps to DATA_W bits.
module fft_r2_butterfly
  import inplace_fft_r2_dif_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [COEF_W-1:0] w_re,
  input  logic signed [COEF_W-1:0] w_im,
  input  logic                     scale_en,
  output logic signed [DATA_W-1:0] top_re,
  output logic signed [DATA_W-1:0] top_im,
  output logic signed [DATA_W-1:0] bot_re,
  output logic signed [DATA_W-1:0] bot_im
);

  localparam int PW = DATA_W + COEF_W;

  // Halve (when scaling) or wrap a widened sum/difference back to DATA_W.
  function automatic logic signed [DATA_W-1:0] scale_wrap(
    input logic signed [DATA_W:0] v,
    input logic                   en
  );
    logic signed [DATA_W:0] half;
    half = v >>> 1;
    return en ? half[DATA_W-1:0] : v[DATA_W-1:0];
  endfunction

  // Drop the Q1.14 fraction bits of a product and wrap to DATA_W.
  function automatic logic signed [DATA_W-1:0] frac_trunc(
    input logic signed [PW-1:0] v
  );
    logic signed [PW-1:0] sh;
    sh = v >>> COEF_FRAC;
    return sh[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] d_re, d_im;
  logic signed [PW-1:0]     dre_x, dim_x, wre_x, wim_x;
  logic signed [PW-1:0]     p_re, p_im;

  // Sum path, difference path and complex twiddle multiply.
  always_comb begin
    sum_re = {a_re[DATA_W-1], a_re} + {b_re[DATA_W-1], b_re};
    sum_im = {a_im[DATA_W-1], a_im} + {b_im[DATA_W-1], b_im};
    dif_re = {a_re[DATA_W-1], a_re} - {b_re[DATA_W-1], b_re};
    dif_im = {a_im[DATA_W-1], a_im} - {b_im[DATA_W-1], b_im};

    top_re = scale_wrap(sum_re, scale_en);
    top_im = scale_wrap(sum_im, scale_en);
    d_re   = scale_wrap(dif_re, scale_en);
    d_im   = scale_wrap(dif_im, scale_en);

    dre_x  = {{COEF_W{d_re[DATA_W-1]}}, d_re};
    dim_x  = {{COEF_W{d_im[DATA_W-1]}}, d_im};
    wre_x  = {{DATA_W{w_re[COEF_W-1]}}, w_re};
    wim_x  = {{DATA_W{w_im[COEF_W-1]}}, w_im};

    p_re   = dre_x * wre_x - dim_x * wim_x;
    p_im   = dre_x * wim_x + dim_x * wre_x;

    bot_re = frac_trunc(p_re);
    bot_im = frac_trunc(p_im);
  end

endmodule

// File: rtl/inplace_fft_r2_dif.sv
// 64-point radix-2 DIF FFT computed in place in a 64-word flop memory
// with one butterfly. Stage 1 runs while the second half of the input
// streams in, stages 2-5 run back to back, stage 6 streams result pairs
// (bit-reversed order) on two output lanes.
// Build option: define FFT_STAGE_SCALE_EN to halve every butterfly
// sum/difference (outputs = DFT/64); otherwise results are unscaled.
module inplace_fft_r2_dif
  import inplace_fft_r2_dif_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        valid,
  input  logic [15:0] inReal,
  input  logic [15:0] inImag,
  output logic [15:0] outReal0,
  output logic [15:0] outImag0,
  output logic [15:0] outReal1,
  output logic [15:0] outImag1,
  output logic        out_valid
);

`ifdef FFT_STAGE_SCALE_EN
  localparam logic SCALE_EN = 1'b1;
`else
  localparam logic SCALE_EN = 1'b0;
`endif

  state_t state_q, state_d;

  // stage_q holds (stage - 1): 0 = stage 1 (LOAD), 1..4 = stages 2..5,
  // 5 = stage 6 (OUTPUT). cnt_q is the sample index in LOAD and the
  // butterfly index elsewhere.
  logic [2:0]          stage_q;
  logic [LOG2N-1:0]    cnt_q;
  logic [2*DATA_W-1:0] mem [N];

  logic [4:0]          bidx, low_mask, tw_idx;
  logic [LOG2N-1:0]    span, top_addr, bot_addr;
  logic                last_bfly;

  logic [2*DATA_W-1:0]      word_a, word_b;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [COEF_W-1:0] w_re, w_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  // Butterfly addressing: span h = 32 >> stage_q; the top address inserts a
  // zero at bit log2(h) of the butterfly index, bot = top + h.
  always_comb begin
    bidx      = cnt_q[4:0];
    low_mask  = 5'd31 >> stage_q;
    span      = 6'd32 >> stage_q;
    top_addr  = {bidx & ~low_mask, 1'b0} | {1'b0, bidx & low_mask};
    bot_addr  = top_addr | span;
    tw_idx    = (bidx & low_mask) << stage_q;
    last_bfly = (bidx == 5'd31);
  end

  // Operand fetch: during LOAD the lower operand is the incoming sample.
  always_comb begin
    word_a = mem[top_addr];
    word_b = (state_q == ST_LOAD) ? {inReal, inImag} : mem[bot_addr];
    a_re   = word_a[2*DATA_W-1:DATA_W];
    a_im   = word_a[DATA_W-1:0];
    b_re   = word_b[2*DATA_W-1:DATA_W];
    b_im   = word_b[DATA_W-1:0];
    w_re   = TW_RE[tw_idx];
    w_im   = TW_IM[tw_idx];
  end

  fft_r2_butterfly u_bfly (
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .w_re     (w_re),
    .w_im     (w_im),
    .scale_en (SCALE_EN),
    .top_re   (top_re),
    .top_im   (top_im),
    .bot_re   (bot_re),
    .bot_im   (bot_im)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    if (valid && (cnt_q == 6'd63)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_bfly && (stage_q == 3'd4)) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (last_bfly) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Sample / butterfly counter and stage counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (valid) begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) stage_q <= 3'd1;
          end
        end
        ST_COMPUTE: begin
          cnt_q <= {1'b0, bidx + 5'd1};
          if (last_bfly) stage_q <= stage_q + 3'd1;
        end
        ST_OUTPUT: begin
          cnt_q <= {1'b0, bidx + 5'd1};
          if (last_bfly) stage_q <= '0;
        end
        default: begin
          cnt_q   <= '0;
          stage_q <= '0;
        end
      endcase
    end
  end

  // Working memory: first half of the input is stored raw, later samples
  // and compute stages write both butterfly results back in place.
  always_ff @(posedge clk) begin
    if ((state_q == ST_LOAD) && valid) begin
      if (!cnt_q[5]) begin
        mem[cnt_q] <= {inReal, inImag};
      end else begin
        mem[top_addr] <= {top_re, top_im};
        mem[bot_addr] <= {bot_re, bot_im};
      end
    end else if (state_q == ST_COMPUTE) begin
      mem[top_addr] <= {top_re, top_im};
      mem[bot_addr] <= {bot_re, bot_im};
    end
  end

  // Output lanes: stage-6 results are registered, held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      outReal0  <= '0;
      outImag0  <= '0;
      outReal1  <= '0;
      outImag1  <= '0;
      out_valid <= 1'b0;
    end else if (state_q == ST_OUTPUT) begin
      outReal0  <= top_re;
      outImag0  <= top_im;
      outReal1  <= bot_re;
      outImag1  <= bot_im;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inplace_fft_r2_dif.sv
// Self-checking bench for inplace_fft_r2_dif: directed runs (impulse, DC,
// tone, tone with valid gap, random with control noise, mid-run reset),
// scoreboard of expected output pairs from an independent reference FFT.
module tb_inplace_fft_r2_dif;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [15:0] inReal, inImag;
  logic [15:0] outReal0, outImag0, outReal1, outImag1;
  logic        out_valid;

`ifdef FFT_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  inplace_fft_r2_dif dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid     (valid),
    .inReal    (inReal),
    .inImag    (inImag),
    .outReal0  (outReal0),
    .outImag0  (outImag0),
    .outReal1  (outReal1),
    .outImag1  (outImag1),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r0;
    int i0;
    int r1;
    int i1;
  } pair_t;

  pair_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    sr[64];
  int    si[64];
  int    first_k;
  int    nvalid;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int tw_re(input int k);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
    return rnd(16384.0 * $cos(ang));
  endfunction

  function automatic int tw_im(input int k);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
    return rnd(-16384.0 * $sin(ang));
  endfunction

  function automatic int shrink(input int v);
    if (SCALE) return v >>> 1;
    return wrap16(v);
  endfunction

  // Reference: textbook in-place DIF over six stages, then pairs (2i, 2i+1).
  task automatic model_push();
    int xr[64];
    int xi[64];
    int h, t, u, k, sre, sim, dre, dim, wr, wi;
    pair_t p;
    for (int n = 0; n < 64; n++) begin
      xr[n] = sr[n];
      xi[n] = si[n];
    end
    for (int s = 1; s <= 6; s++) begin
      h = 64 >> s;
      for (int b = 0; b < 32; b++) begin
        t   = (b / h) * 2 * h + (b % h);
        u   = t + h;
        k   = (b % h) << (s - 1);
        sre = shrink(xr[t] + xr[u]);
        sim = shrink(xi[t] + xi[u]);
        dre = shrink(xr[t] - xr[u]);
        dim = shrink(xi[t] - xi[u]);
        wr  = tw_re(k);
        wi  = tw_im(k);
        xr[t] = sre;
        xi[t] = sim;
        xr[u] = wrap16((dre * wr - dim * wi) >>> 14);
        xi[u] = wrap16((dre * wi + dim * wr) >>> 14);
      end
    end
    for (int i = 0; i < 32; i++) begin
      p.r0 = xr[2*i];
      p.i0 = xi[2*i];
      p.r1 = xr[2*i+1];
      p.i1 = xi[2*i+1];
      exp_q.push_back(p);
    end
  endtask

  task automatic push_const(input int re, input int im);
    pair_t p;
    p.r0 = re; p.i0 = im; p.r1 = re; p.i1 = im;
    for (int i = 0; i < 32; i++) exp_q.push_back(p);
  endtask

  // Start a transform and stream all 64 samples; optional valid gap.
  task automatic load_samples(input int gap_after, input int gap_len, input bit noise);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = noise;
    for (int n = 0; n < 64; n++) begin
      if ((n == gap_after + 1) && (gap_len > 0)) begin
        valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      valid  = 1'b1;
      inReal = 16'(sr[n]);
      inImag = 16'(si[n]);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  // Collect output pairs after edge L, compare against the scoreboard.
  task automatic collect(input string tag, input bit noise);
    int    k;
    int    idx;
    pair_t e;
    k = 0; idx = 0; first_k = -1; nvalid = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (noise) begin
        valid  = 1'b1;
        inReal = 16'($urandom);
        inImag = 16'($urandom);
        start  = (k < 100);
      end
      if (out_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        nvalid++;
        if (exp_q.size() == 0) begin
          chk($sformatf("%s sb_underflow", tag), exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s p%0d re0", tag, idx), int'($signed(outReal0)), e.r0);
          chk($sformatf("%s p%0d im0", tag, idx), int'($signed(outImag0)), e.i0);
          chk($sformatf("%s p%0d re1", tag, idx), int'($signed(outReal1)), e.r1);
          chk($sformatf("%s p%0d im1", tag, idx), int'($signed(outImag1)), e.i1);
        end
        idx++;
      end else if (nvalid > 0) begin
        break;
      end
    end
    valid = 1'b0;
    start = 1'b0;
    chk($sformatf("%s first_valid_edge", tag), first_k, 129);
    chk($sformatf("%s valid_cycles", tag), nvalid, 32);
    chk($sformatf("%s sb_leftover", tag), exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 64; n++) begin
      sr[n] = 0;
      si[n] = 0;
    end
    sr[0] = SCALE ? 64 : 1;
  endtask

  task automatic set_tone();
    for (int n = 0; n < 64; n++) begin
      sr[n] = rnd(8192.0 * $cos(2.0 * 3.14159265358979323846 * real'(n) / 64.0));
      si[n] = 0;
    end
  endtask

  initial begin
    int highs;
    rst = 1'b1; start = 1'b0; valid = 1'b0; inReal = '0; inImag = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset outReal0", int'(outReal0), 0);
    chk("reset outImag0", int'(outImag0), 0);
    chk("reset outReal1", int'(outReal1), 0);
    chk("reset outImag1", int'(outImag1), 0);
    rst = 1'b0;

    // Impulse: flat spectrum of ones
    set_impulse();
    push_const(1, 0);
    load_samples(-10, 0, 1'b0);
    collect("impulse", 1'b0);

    // DC
    for (int n = 0; n < 64; n++) begin
      sr[n] = 256;
      si[n] = 0;
    end
    model_push();
    load_samples(-10, 0, 1'b0);
    collect("dc", 1'b0);

    // Single-bin tone
    set_tone();
    model_push();
    load_samples(-10, 0, 1'b0);
    collect("tone", 1'b0);

    // Same tone with a 5-cycle valid gap after sample 20
    model_push();
    load_samples(20, 5, 1'b0);
    collect("tone_gap", 1'b0);

    // Random full-scale data, start/valid toggling outside LOAD
    for (int n = 0; n < 64; n++) begin
      sr[n] = int'($urandom_range(65535)) - 32768;
      si[n] = int'($urandom_range(65535)) - 32768;
    end
    model_push();
    load_samples(-10, 0, 1'b1);
    collect("random_noise", 1'b1);

    // Impulse so the lanes hold nonzero values before the abort
    set_impulse();
    push_const(1, 0);
    load_samples(-10, 0, 1'b0);
    collect("impulse_pre", 1'b0);

    // Abort during stage 3 (edges L+33..L+64)
    set_tone();
    load_samples(-10, 0, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort outReal0", int'(outReal0), 0);
    chk("abort outImag0", int'(outImag0), 0);
    chk("abort outReal1", int'(outReal1), 0);
    chk("abort outImag1", int'(outImag1), 0);
    highs = 0;
    repeat (150) begin
      @(negedge clk);
      if (out_valid === 1'b1) highs++;
    end
    chk("abort quiet", highs, 0);

    // Full impulse run after the abort
    set_impulse();
    push_const(1, 0);
    load_samples(-10, 0, 1'b0);
    collect("impulse_post", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
